// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared func3 codes, LSU state encoding and byte-enable constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // Unlisted func3 encodings fall through to a word access.
  function automatic acc_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module   : load_align
// Brief    : Lane select and sign/zero extension of raw load data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_result = i_rdata;
    case (i_func3)
      F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_result = {24'd0, w_byte};
      F3_H:    o_result = {{16{w_half[15]}}, w_half};
      F3_HU:   o_result = {16'd0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// Module   : mem_lsu
// Brief    : MEM-stage load/store unit driving a req/ack data-memory bus.
//            Optional build macro: MISALIGN_TRAP_EN (trap misaligned accesses).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_MEM_I,
  input  logic        MemRead_MEM_I,
  input  logic        MemWrite_MEM_I,
  input  logic [2:0]  func3_MEM_I,
  input  logic [31:0] ALU_result_MEM_I,
  input  logic [31:0] Rd_data2_MEM_I,
  output logic        stall_MEM_O,
  output logic        done_MEM_O,
  output logic [31:0] Rd_mem_data_MEM_O,
  output logic        bus_err_MEM_O,
  output logic        misalign_MEM_O,
  output logic        dmem_req_O,
  output logic        dmem_we_O,
  output logic [31:0] dmem_addr_O,
  output logic [31:0] dmem_wdata_O,
  output logic [3:0]  dmem_be_O,
  input  logic        dmem_ack_I,
  input  logic [31:0] dmem_rdata_I
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(MAX_WAIT - 1);

  lsu_state_t       r_state;
  lsu_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic [1:0]       r_lane;
  logic [2:0]       r_func3;
  logic [31:0]      r_ld_data;
  logic             r_bus_err;
  logic             r_misalign;

  logic             w_access;
  logic             w_is_write;
  logic             w_misalign;
  logic             w_timeout;
  logic             w_stall;
  logic [31:0]      w_wdata;
  logic [3:0]       w_be;
  logic [31:0]      w_ld_fmt;

  // A simultaneous read+write request is carried out as a read.
  assign w_access   = valid_MEM_I & (MemRead_MEM_I | MemWrite_MEM_I);
  assign w_is_write = MemWrite_MEM_I & ~MemRead_MEM_I;
  assign w_timeout  = (r_state == LSU_REQ) & ~dmem_ack_I & (r_wait_cnt == c_wait_last);

  always_comb begin
    w_wdata = Rd_data2_MEM_I;
    w_be    = BE_ALL;
    case (f3_size(func3_MEM_I))
      SZ_BYTE: begin
        w_wdata = {4{Rd_data2_MEM_I[7:0]}};
        w_be    = BE_BYTE0 << ALU_result_MEM_I[1:0];
      end
      SZ_HALF: begin
        w_wdata = {2{Rd_data2_MEM_I[15:0]}};
        w_be    = ALU_result_MEM_I[1] ? BE_HALF_HI : BE_HALF_LO;
      end
      default: begin
        w_wdata = Rd_data2_MEM_I;
        w_be    = BE_ALL;
      end
    endcase
    if (!w_is_write) w_be = BE_ALL;
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    case (f3_size(func3_MEM_I))
      SZ_HALF: w_misalign = ALU_result_MEM_I[0];
      SZ_WORD: w_misalign = (ALU_result_MEM_I[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  load_align u_load_align (
    .i_rdata  (dmem_rdata_I),
    .i_lane   (r_lane),
    .i_func3  (r_func3),
    .o_result (w_ld_fmt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        if (w_access) begin
          w_stall     = 1'b1;
          w_state_nxt = w_misalign ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ: begin
        w_stall = 1'b1;
        if (dmem_ack_I || w_timeout) w_state_nxt = LSU_DONE;
      end
      LSU_DONE: w_state_nxt = LSU_IDLE;
      default:  w_state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LSU_IDLE;
      r_wait_cnt <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_lane     <= '0;
      r_func3    <= '0;
      r_ld_data  <= '0;
      r_bus_err  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        LSU_IDLE: begin
          if (w_access) begin
            r_addr  <= {ALU_result_MEM_I[31:2], 2'b00};
            r_we    <= w_is_write;
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_lane  <= ALU_result_MEM_I[1:0];
            r_func3 <= func3_MEM_I;
            if (w_misalign) begin
              r_misalign <= 1'b1;
              r_ld_data  <= '0;
            end
          end
        end
        LSU_REQ: begin
          if (dmem_ack_I) begin
            r_ld_data <= w_ld_fmt;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_ld_data <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        LSU_DONE: begin
          r_wait_cnt <= '0;
          r_bus_err  <= 1'b0;
          r_misalign <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign stall_MEM_O       = w_stall & ~rst;
  assign done_MEM_O        = (r_state == LSU_DONE);
  assign dmem_req_O        = (r_state == LSU_REQ);
  assign Rd_mem_data_MEM_O = r_ld_data;
  assign bus_err_MEM_O     = r_bus_err;
  assign misalign_MEM_O    = r_misalign;
  assign dmem_we_O         = r_we;
  assign dmem_addr_O       = r_addr;
  assign dmem_wdata_O      = r_wdata;
  assign dmem_be_O         = r_be;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// Module   : tb_mem_lsu
// Brief    : Directed self-checking bench for mem_lsu (MAX_WAIT = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_lsu;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] alu_result, rd_data2;
  logic        stall, done, bus_err, misalign;
  logic [31:0] ld_data;
  logic        req, we, ack;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  mem_lsu #(.MAX_WAIT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_MEM_I       (valid),
    .MemRead_MEM_I     (mem_read),
    .MemWrite_MEM_I    (mem_write),
    .func3_MEM_I       (func3),
    .ALU_result_MEM_I  (alu_result),
    .Rd_data2_MEM_I    (rd_data2),
    .stall_MEM_O       (stall),
    .done_MEM_O        (done),
    .Rd_mem_data_MEM_O (ld_data),
    .bus_err_MEM_O     (bus_err),
    .misalign_MEM_O    (misalign),
    .dmem_req_O        (req),
    .dmem_we_O         (we),
    .dmem_addr_O       (addr),
    .dmem_wdata_O      (wdata),
    .dmem_be_O         (be),
    .dmem_ack_I        (ack),
    .dmem_rdata_I      (rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int          done_cyc, stall_cnt, req_cnt;
  logic [31:0] s_addr, s_wdata, s_data;
  logic [3:0]  s_be;
  logic        s_we, s_berr, s_mis;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one access in the current IDLE cycle and follows it to DONE.
  // ack_wait < 0 never acknowledges.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int ack_wait);
    done_cyc = 0; stall_cnt = 0; req_cnt = 0;
    s_addr = '0; s_wdata = '0; s_data = '0; s_be = '0; s_we = 1'b0;
    s_berr = 1'b0; s_mis = 1'b0;
    valid = 1'b1; mem_read = rd; mem_write = wr; func3 = f3;
    alu_result = a; rd_data2 = wd; rdata = rdat; ack = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      #1;
      if (stall) stall_cnt++;
      if (done) begin
        done_cyc = cyc;
        s_data = ld_data; s_berr = bus_err; s_mis = misalign;
        break;
      end
      if (req) begin
        req_cnt++;
        s_addr = addr; s_wdata = wdata; s_be = be; s_we = we;
        ack = (ack_wait >= 0) && (req_cnt == ack_wait + 1);
      end else begin
        ack = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; ack = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; func3 = '0;
    alu_result = '0; rd_data2 = '0; ack = 1'b0; rdata = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("rst_req",   req,     0);
    check("rst_stall", stall,   0);
    check("rst_done",  done,    0);
    check("rst_flags", {bus_err, misalign, we}, 0);
    check("rst_data",  ld_data, 0);
    check("rst_bus",   addr | wdata | {28'd0, be}, 0);
    step();

    // SW, immediate ack
    run_access(1'b0, 1'b1, F3_W, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0);
    check("sw_done_cyc", done_cyc, 3);
    check("sw_stall",    stall_cnt, 2);
    check("sw_addr",     s_addr, 32'h0000_0104);
    check("sw_be",       s_be, 4'b1111);
    check("sw_wdata",    s_wdata, 32'hDEAD_BEEF);
    check("sw_we",       s_we, 1);

    // LB with three wait cycles
    run_access(1'b1, 1'b0, F3_B, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3);
    check("lb_done_cyc", done_cyc, 6);
    check("lb_stall",    stall_cnt, 5);
    check("lb_data",     s_data, 32'hFFFF_FF80);
    check("lb_addr",     s_addr, 32'h0000_0100);
    check("lb_we_be",    {s_we, s_be}, 5'b0_1111);

    run_access(1'b1, 1'b0, F3_HU, 32'h0000_0102, 32'h0, 32'h8001_1234, 0);
    check("lhu_data", s_data, 32'h0000_8001);
    run_access(1'b1, 1'b0, F3_H, 32'h0000_0102, 32'h0, 32'h8001_1234, 0);
    check("lh_data",  s_data, 32'hFFFF_8001);
    run_access(1'b1, 1'b0, F3_BU, 32'h0000_0101, 32'h0, 32'h0000_9A00, 1);
    check("lbu_data", s_data, 32'h0000_009A);

    run_access(1'b0, 1'b1, F3_B, 32'h0000_0101, 32'h0000_00AB, 32'h0, 0);
    check("sb_wdata", s_wdata, 32'hABAB_ABAB);
    check("sb_be",    s_be, 4'b0010);
    check("sb_addr",  s_addr, 32'h0000_0100);
    run_access(1'b0, 1'b1, F3_H, 32'h0000_0102, 32'h0000_1234, 32'h0, 0);
    check("sh_wdata", s_wdata, 32'h1234_1234);
    check("sh_be",    s_be, 4'b1100);

    // Both read and write set: performed as a read
    run_access(1'b1, 1'b1, F3_W, 32'h0000_0110, 32'h5555_5555, 32'h0BAD_F00D, 0);
    check("rw_we_be", {s_we, s_be}, 5'b0_1111);
    check("rw_data",  s_data, 32'h0BAD_F00D);

    // Timeout with MAX_WAIT = 4
    run_access(1'b1, 1'b0, F3_W, 32'h0000_010C, 32'h0, 32'hFFFF_FFFF, -1);
    check("tmo_req_cnt",  req_cnt, 4);
    check("tmo_done_cyc", done_cyc, 6);
    check("tmo_bus_err",  s_berr, 1);
    check("tmo_data",     s_data, 0);
    ack = 1'b1;
    #1;
    check("late_ack_req",   req, 0);
    check("late_ack_stall", stall, 0);
    step();
    check("late_ack_done", done, 0);
    check("late_ack_hold", ld_data, 0);
    ack = 1'b0;

    // Misaligned word load
    run_access(1'b1, 1'b0, F3_W, 32'h0000_0102, 32'h0, 32'h1122_3344, 0);
`ifdef MISALIGN_TRAP_EN
    check("mis_req_cnt",  req_cnt, 0);
    check("mis_done_cyc", done_cyc, 2);
    check("mis_flag",     s_mis, 1);
    check("mis_data",     s_data, 0);
`else
    check("mis_req_cnt",  req_cnt, 1);
    check("mis_addr",     s_addr, 32'h0000_0100);
    check("mis_be",       s_be, 4'b1111);
    check("mis_flag",     s_mis, 0);
    check("mis_data",     s_data, 32'h1122_3344);
`endif
    check("mis_berr_clr", s_berr, 0);

    // Reset while in REQ
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func3 = F3_W;
    alu_result = 32'h0000_0200; rdata = 32'h0;
    #1;
    check("rreq_stall_idle", stall, 1);
    step();
    check("rreq_in_req", req, 1);
    rst = 1'b1; valid = 1'b0; mem_read = 1'b0;
    step();
    check("rreq_req_drop",   req, 0);
    check("rreq_stall_drop", stall, 0);
    rst = 1'b0; ack = 1'b1;
    step();
    check("rreq_late_ack", {done, req}, 0);
    ack = 1'b0;
    run_access(1'b1, 1'b0, F3_W, 32'h0000_0208, 32'h0, 32'hCAFE_F00D, 1);
    check("post_rst_done_cyc", done_cyc, 4);
    check("post_rst_data",     s_data, 32'hCAFE_F00D);
    check("post_rst_addr",     s_addr, 32'h0000_0208);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
